// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// State codes, access-size codes, byte-enable and lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  function automatic logic lsu_misaligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic r;
    r = 1'b1;
    unique case (1'b1)
      sz == SZ_B: r = 1'b0;
      sz == SZ_H: r = off[0];
      sz == SZ_W: r = (off != 2'd0);
      default:    r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lsu_be(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [3:0] r;
    r = BE_W;
    unique case (1'b1)
      sz == SZ_B: r = BE_B << off;
      sz == SZ_H: r = BE_H << off;
      default:    r = BE_W;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lsu_lanes(
    input logic [1:0]  sz,
    input logic [31:0] wd
  );
    logic [31:0] r;
    r = wd;
    unique case (1'b1)
      sz == SZ_B: r = {4{wd[7:0]}};
      sz == SZ_H: r = {2{wd[15:0]}};
      default:    r = wd;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select with sign/zero extension.
// Pure combinational; shared with future cache stages.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{off_i, 3'b000} +: 8];
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = rdata_i;
    unique case (1'b1)
      size_i == SZ_B: data_o = {{24{b[7] & ~uns_i}}, b};
      size_i == SZ_H: data_o = {{16{h[15] & ~uns_i}}, h};
      default:        data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage: one load/store per request over a req/ack RAM.
// Optional ack watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic [4:0]        LOGISIM_CLOCK_TREE_0,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic              ram_ack,
  input  logic [31:0]       ram_rdata,
  output logic              stall,
  output logic [31:0]       ld_data,
  output logic              done,
  output logic              misalign
`ifdef LSU_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  logic clk;
  logic unused_clk;
  assign clk = LOGISIM_CLOCK_TREE_0[4];
  assign unused_clk = ^LOGISIM_CLOCK_TREE_0[3:0];

  lsu_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       ld_q;
  logic              done_q;
  logic              mis_q;
  logic              mis_in;
  logic [31:0]       ld_ext;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]        cnt_q;
  logic              tmo_q;
`endif

  assign mis_in = lsu_misaligned(mem_size, mem_addr[1:0]);

  lsu_load_align u_align (
    .rdata_i (ram_rdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .uns_i   (uns_q),
    .data_o  (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      ld_q    <= 32'd0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= 8'd0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (mem_valid && mis_in) begin
            mis_q <= 1'b1;
          end else if (mem_valid) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            we_q    <= mem_write;
            be_q    <= lsu_be(mem_size, mem_addr[1:0]);
            addr_q  <= {mem_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= lsu_lanes(mem_size, mem_wdata);
            off_q   <= mem_addr[1:0];
            size_q  <= mem_size;
            uns_q   <= mem_unsigned;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
          end
        end
        REQ, WAIT: begin
          if (ram_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            done_q  <= 1'b1;
            ld_q    <= we_q ? 32'd0 : ld_ext;
`ifdef LSU_TIMEOUT_EN
          end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
            // Watchdog expiry abandons the access without a done pulse
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ld_q    <= 32'd0;
            tmo_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= WAIT;
`else
          end else begin
            state_q <= WAIT;
`endif
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall asserts combinationally so the core freezes on the request cycle
  assign stall = ((state_q == IDLE) & mem_valid & ~mis_in)
               | (state_q == REQ) | (state_q == WAIT);

  assign ram_req   = req_q;
  assign ram_we    = we_q;
  assign ram_be    = be_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ld_data   = ld_q;
  assign done      = done_q;
  assign misalign  = mis_q;
`ifdef LSU_TIMEOUT_EN
  assign timeout   = tmo_q;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed self-checking bench for lsu_mem_stage.
// Timeout scenario compiled in only with LSU_TIMEOUT_EN.
module tb_lsu_mem_stage;

  logic [4:0]  ctree;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;
  logic        stall;
  logic [31:0] ld_data;
  logic        done;
  logic        misalign;
`ifdef LSU_TIMEOUT_EN
  logic        timeout;
`endif

  int pass_cnt = 0;
  int total = 0;

  lsu_mem_stage #(
    .ADDR_W(32)
`ifdef LSU_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(4)
`endif
  ) dut (
    .LOGISIM_CLOCK_TREE_0(ctree),
    .rst_n(rst_n),
    .mem_valid(mem_valid),
    .mem_write(mem_write),
    .mem_size(mem_size),
    .mem_unsigned(mem_unsigned),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .ram_req(ram_req),
    .ram_we(ram_we),
    .ram_be(ram_be),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_ack(ram_ack),
    .ram_rdata(ram_rdata),
    .stall(stall),
    .ld_data(ld_data),
    .done(done),
    .misalign(misalign)
`ifdef LSU_TIMEOUT_EN
    ,
    .timeout(timeout)
`endif
  );

  initial ctree = 5'd0;
  always #5 ctree[4] = ~ctree[4];

  task automatic step;
    @(posedge ctree[4]);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd);
    mem_valid = 1'b1;
    mem_write = wr;
    mem_size = sz;
    mem_unsigned = uns;
    mem_addr = a;
    mem_wdata = wd;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n = 1'b0;
    mem_valid = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
    mem_addr = 0; mem_wdata = 0; ram_ack = 0; ram_rdata = 0;
    step(); step();
    v = {ram_req, ram_we, ram_be, stall, done, misalign, 23'd0};
    total++;
    if (v !== 32'd0) $display("FAIL reset_ctl: got %h expected 0", v);
    else pass_cnt++;
    total++;
    if ((ram_addr | ram_wdata | ld_data) !== 32'd0)
      $display("FAIL reset_data: got %h/%h/%h expected 0",
               ram_addr, ram_wdata, ld_data);
    else pass_cnt++;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_sw_wait;
    int stalls = 0;
    int dones = 0;
    issue(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    #1;
    stalls += int'(stall);
    total++;
    if (ram_req !== 1'b0) $display("FAIL sw_req_early: got %b expected 0", ram_req);
    else pass_cnt++;
    step();
    mem_valid = 0;
    stalls += int'(stall);
    total++;
    if ({ram_req, ram_we, ram_be} !== 6'b111111)
      $display("FAIL sw_ctl: got %b expected 111111", {ram_req, ram_we, ram_be});
    else pass_cnt++;
    total++;
    if (ram_addr !== 32'h100 || ram_wdata !== 32'hDEADBEEF)
      $display("FAIL sw_addr_data: got %h %h expected 00000100 deadbeef",
               ram_addr, ram_wdata);
    else pass_cnt++;
    step();
    stalls += int'(stall);
    dones += int'(done);
    total++;
    if (ram_req !== 1'b1 || ram_addr !== 32'h100)
      $display("FAIL sw_wait_hold: got %b %h expected 1 00000100", ram_req, ram_addr);
    else pass_cnt++;
    step();
    stalls += int'(stall);
    dones += int'(done);
    ram_ack = 1'b1;
    ram_rdata = 32'h5555AAAA;
    step();
    ram_ack = 1'b0;
    stalls += int'(stall);
    dones += int'(done);
    total++;
    if ({done, ram_req, ld_data} !== {2'b10, 32'd0})
      $display("FAIL sw_done: got %b%b %h expected 10 00000000", done, ram_req, ld_data);
    else pass_cnt++;
    step();
    dones += int'(done);
    total++;
    if (stalls !== 4) $display("FAIL sw_stall_cycles: got %0d expected 4", stalls);
    else pass_cnt++;
    total++;
    if (dones !== 1) $display("FAIL sw_done_count: got %0d expected 1", dones);
    else pass_cnt++;
  endtask

  task automatic test_sb_immediate;
    issue(1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5);
    step();
    mem_valid = 0;
    total++;
    if (ram_be !== 4'b1000 || ram_wdata !== 32'hA5A5A5A5 || ram_addr !== 32'h100)
      $display("FAIL sb_lanes: got %b %h %h expected 1000 a5a5a5a5 00000100",
               ram_be, ram_wdata, ram_addr);
    else pass_cnt++;
    ram_ack = 1'b1;
    step();
    ram_ack = 1'b0;
    total++;
    if (done !== 1'b1 || stall !== 1'b0)
      $display("FAIL sb_no_wait: got done=%b stall=%b expected 1 0", done, stall);
    else pass_cnt++;
    step();
  endtask

  task automatic do_load(input string nm, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] rd, input logic [3:0] be,
                         input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'hFFFFFFFF);
    step();
    mem_valid = 0;
    total++;
    if (ram_we !== 1'b0 || ram_be !== be)
      $display("FAIL %s_be: got we=%b be=%b expected 0 %b", nm, ram_we, ram_be, be);
    else pass_cnt++;
    step();
    ram_ack = 1'b1;
    ram_rdata = rd;
    step();
    ram_ack = 1'b0;
    ram_rdata = 32'h0;
    total++;
    if (done !== 1'b1 || ld_data !== exp)
      $display("FAIL %s_data: got done=%b %h expected 1 %h", nm, done, ld_data, exp);
    else pass_cnt++;
    step();
    total++;
    if (ld_data !== exp)
      $display("FAIL %s_hold: got %h expected %h", nm, ld_data, exp);
    else pass_cnt++;
  endtask

  task automatic test_load;
    do_load("lb", 2'd0, 1'b0, 32'h202, 32'h12F03456, 4'b0100, 32'hFFFFFFF0);
    do_load("lbu", 2'd0, 1'b1, 32'h202, 32'h12F03456, 4'b0100, 32'h000000F0);
    do_load("lh_hi", 2'd1, 1'b0, 32'h202, 32'h12F03456, 4'b1100, 32'h000012F0);
    do_load("lh_lo", 2'd1, 1'b0, 32'h200, 32'h0000F00D, 4'b0011, 32'hFFFFF00D);
    do_load("lhu", 2'd1, 1'b1, 32'h200, 32'h0000F00D, 4'b0011, 32'h0000F00D);
    do_load("lw", 2'd2, 1'b0, 32'h204, 32'h89ABCDEF, 4'b1111, 32'h89ABCDEF);
  endtask

  task automatic test_misalign;
    logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] ad [3] = '{32'h301, 32'h102, 32'h100};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, sz[i], 1'b0, ad[i], 32'h0);
      #1;
      total++;
      if (stall !== 1'b0) $display("FAIL mis%0d_stall: got %b expected 0", i, stall);
      else pass_cnt++;
      step();
      mem_valid = 0;
      total++;
      if (misalign !== 1'b1 || ram_req !== 1'b0)
        $display("FAIL mis%0d_pulse: got mis=%b req=%b expected 1 0", i, misalign, ram_req);
      else pass_cnt++;
      step();
      total++;
      if (misalign !== 1'b0 || ram_req !== 1'b0 || stall !== 1'b0)
        $display("FAIL mis%0d_after: got %b%b%b expected 000", i, misalign, ram_req, stall);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid;
    issue(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
    step();
    mem_valid = 0;
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({ram_req, stall, done, ld_data} !== 35'd0)
      $display("FAIL rst_mid_outs: got %b%b%b %h expected 000 0", ram_req, stall, done, ld_data);
    else pass_cnt++;
    #1 rst_n = 1'b1;
    step();
    ram_ack = 1'b1;
    ram_rdata = 32'h77777777;
    step();
    ram_ack = 1'b0;
    total++;
    if ({ram_req, stall, done, ld_data} !== 35'd0)
      $display("FAIL rst_late_ack: got %b%b%b %h expected 000 0", ram_req, stall, done, ld_data);
    else pass_cnt++;
    step();
    total++;
    if (done !== 1'b0 || ram_req !== 1'b0)
      $display("FAIL rst_idle: got done=%b req=%b expected 0 0", done, ram_req);
    else pass_cnt++;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    do_load("tpre", 2'd2, 1'b0, 32'h500, 32'h13572468, 4'b1111, 32'h13572468);
    issue(1'b0, 2'd2, 1'b0, 32'h504, 32'h0);
    step();
    mem_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (timeout !== 1'b0 || ram_req !== 1'b1)
        $display("FAIL tmo_early%0d: got tmo=%b req=%b expected 0 1", i, timeout, ram_req);
      else pass_cnt++;
    end
    step();
    total++;
    if ({timeout, ram_req, done, ld_data} !== {3'b100, 32'd0})
      $display("FAIL tmo_fire: got %b%b%b %h expected 100 0", timeout, ram_req, done, ld_data);
    else pass_cnt++;
    step();
    total++;
    if (timeout !== 1'b0 || stall !== 1'b0)
      $display("FAIL tmo_after: got tmo=%b stall=%b expected 0 0", timeout, stall);
    else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_sw_wait();
    test_sb_immediate();
    test_load();
    test_misalign();
    test_reset_mid();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
